// File: rtl/mac6343_acc.sv
`default_nettype none
// ============================================================================
//  Module   : mac6343_acc
//  Purpose  : Two-stage signed multiply-accumulate for mod-6343 dot products.
//             Stage 1 registers the 26-bit product of two 13-bit signed
//             operands. Stage 2 accumulates products into a 35-bit signed
//             sum and presents the result on the last term of each dot
//             product with a valid/ready handshake.
//  Ports    : clk        - clock, rising edge
//             Reset      - synchronous, active-high reset
//             in_a/in_b  - 13-bit signed operands
//             in_valid   - operands and in_last valid this cycle
//             in_last    - final term of the current dot product
//             in_ready   - block accepts a beat this cycle
//             out_sum    - 35-bit signed dot-product sum
//             out_valid  - out_sum holds an unconsumed result
//             out_ready  - downstream consumes out_sum this cycle
//             ovf        - sticky term-count overflow flag
//  Options  : MAC6343_TERMCNT_EN - builds the 11-bit term counter that drives
//             ovf; when undefined ovf is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mac6343_acc #(
  parameter int MAX_TERMS = 1023
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic signed [12:0] in_a,
  input  logic signed [12:0] in_b,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic signed [34:0] out_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               ovf
);

  logic               r_s1Valid;
  logic               r_s1Last;
  logic signed [25:0] r_s1Prod;
  logic signed [34:0] r_acc;
  logic signed [34:0] r_outSum;
  logic               r_outValid;

  logic               w_stall;
  logic               w_accept;
  logic               w_load;
  logic signed [25:0] w_prod;
  logic signed [34:0] w_s1Ext;

  // Only a pending last product can be blocked: it needs the output register,
  // which is still occupied by an unconsumed result.
  assign w_stall  = r_s1Valid & r_s1Last & r_outValid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  assign w_load   = ~w_stall & r_s1Valid & r_s1Last;

  assign w_prod   = 26'(in_a) * 26'(in_b);
  assign w_s1Ext  = {{9{r_s1Prod[25]}}, r_s1Prod};

  assign out_sum   = r_outSum;
  assign out_valid = r_outValid;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_s1Valid  <= 1'b0;
      r_s1Last   <= 1'b0;
      r_s1Prod   <= '0;
      r_acc      <= '0;
      r_outSum   <= '0;
      r_outValid <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_s1Valid <= w_accept;
        if (w_accept) begin
          r_s1Prod <= w_prod;
          r_s1Last <= in_last;
        end
        if (r_s1Valid) begin
          if (r_s1Last) begin
            // Closing term: publish the final sum and start the next
            // dot product from zero in the same cycle.
            r_outSum <= r_acc + w_s1Ext;
            r_acc    <= '0;
          end else begin
            r_acc <= r_acc + w_s1Ext;
          end
        end
      end
      // A load wins over a consume so back-to-back results have no bubble.
      if (w_load) begin
        r_outValid <= 1'b1;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

`ifdef MAC6343_TERMCNT_EN
  localparam logic [10:0] c_MAX_CNT = 11'(MAX_TERMS);

  logic [10:0] r_termCnt;
  logic        r_ovf;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_termCnt <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      if (r_termCnt == c_MAX_CNT) begin
        r_ovf <= 1'b1;
      end
      if (in_last) begin
        r_termCnt <= '0;
      end else if (r_termCnt != '1) begin
        // Saturate so a runaway stream cannot wrap back under the limit.
        r_termCnt <= r_termCnt + 11'd1;
      end
    end
  end

  assign ovf = r_ovf;
`else
  // MAX_TERMS only matters when the counter is built; both branches tie ovf
  // off so the flag reads 0 regardless of the configured limit.
  if (MAX_TERMS > 0) begin : g_ovfTied
    assign ovf = 1'b0;
  end else begin : g_ovfTiedNoLimit
    assign ovf = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac6343_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac6343_acc
//  Purpose  : Self-checking bench for mac6343_acc. A table of directed dot
//             products is applied with out_ready held high, followed by
//             hand-written sequences for range, overflow flag, back-to-back
//             results, output stall and mid-stream reset.
//  Options  : MAC6343_TERMCNT_EN - expects ovf to assert on the term past
//             MAX_TERMS; otherwise ovf is expected to stay 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac6343_acc;

  logic               clk;
  logic               Reset;
  logic signed [12:0] in_a;
  logic signed [12:0] in_b;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic signed [34:0] out_sum;
  logic               out_valid;
  logic               out_ready;
  logic               ovf;

  mac6343_acc #(.MAX_TERMS(1023)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     acceptCyc = 0;
  int     lastWaits = 0;
  longint gotQ[$];
  int     gotCyc[$];

  // Result collector: a handshake completes at a rising edge where
  // out_valid and out_ready were both high just before it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!Reset && out_valid && out_ready) begin
      gotQ.push_back(longint'(out_sum));
      gotCyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; leaves the beat on the bus.
  task automatic beat(input int a, input int b, input bit last);
    int waits = 0;
    in_a     = 13'(a);
    in_b     = 13'(b);
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    lastWaits = waits;
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    acceptCyc = cyc;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic waitResults(input string name, input int n);
    int t = 0;
    while (gotQ.size() < n && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk(name, longint'(gotQ.size() >= n), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    Reset = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    gotQ.delete();
    gotCyc.delete();
  endtask

  typedef struct {
    int     n;
    int     a[4];
    int     b[4];
    longint exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0].n = 3; vecs[0].a = '{3, -5, 7, 0};         vecs[0].b = '{4, 6, -8, 0};        vecs[0].exp = -74;
    vecs[1].n = 1; vecs[1].a = '{100, 0, 0, 0};        vecs[1].b = '{100, 0, 0, 0};       vecs[1].exp = 10000;
    vecs[2].n = 1; vecs[2].a = '{-1, 0, 0, 0};         vecs[2].b = '{1, 0, 0, 0};         vecs[2].exp = -1;
    vecs[3].n = 1; vecs[3].a = '{-4096, 0, 0, 0};      vecs[3].b = '{4095, 0, 0, 0};      vecs[3].exp = -16773120;
    vecs[4].n = 2; vecs[4].a = '{4095, -4096, 0, 0};   vecs[4].b = '{4095, -4096, 0, 0};  vecs[4].exp = 33546241;
    vecs[5].n = 4; vecs[5].a = '{1, 2, 3, -14};        vecs[5].b = '{1, 2, 3, 1};         vecs[5].exp = 0;

    Reset     = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;

    // Reset state
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_sum", longint'(out_sum), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_in_ready", longint'(in_ready), 1);

    // Directed table, out_ready held high
    for (int i = 0; i < 6; i++) begin
      gotQ.delete();
      gotCyc.delete();
      for (int j = 0; j < vecs[i].n; j++) begin
        beat(vecs[i].a[j], vecs[i].b[j], j == vecs[i].n - 1);
      end
      idle();
      waitResults($sformatf("vec%0d_wait", i), 1);
      if (gotQ.size() >= 1) begin
        chk($sformatf("vec%0d_sum", i), gotQ[0], vecs[i].exp);
        chk($sformatf("vec%0d_latency", i), longint'(gotCyc[0] - acceptCyc), 2);
      end
      chk($sformatf("vec%0d_pulse", i), longint'(out_valid), 0);
    end

    // Full-range dot product of MAX_TERMS terms
    gotQ.delete();
    gotCyc.delete();
    for (int i = 0; i < 1023; i++) beat(-4096, -4096, i == 1022);
    idle();
    waitResults("maxterms_wait", 1);
    if (gotQ.size() >= 1) chk("maxterms_sum", gotQ[0], 64'sd17163091968);
    chk("maxterms_ovf", longint'(ovf), 0);

    // Term-count overflow: MAX_TERMS non-last beats are legal, one more is not
    for (int i = 0; i < 1023; i++) beat(1, 1, 1'b0);
    chk("ovf_at_limit", longint'(ovf), 0);
    beat(1, 1, 1'b0);
    idle();
`ifdef MAC6343_TERMCNT_EN
    chk("ovf_past_limit", longint'(ovf), 1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", longint'(ovf), 1);
`else
    chk("ovf_past_limit", longint'(ovf), 0);
`endif
    doReset();
    chk("ovf_after_reset", longint'(ovf), 0);

    // Back-to-back single-beat dot products
    beat(100, 100, 1'b1);
    chk("b2b_ready0", longint'(lastWaits), 0);
    beat(-1, 1, 1'b1);
    chk("b2b_ready1", longint'(lastWaits), 0);
    idle();
    waitResults("b2b_wait", 2);
    if (gotQ.size() >= 2) begin
      chk("b2b_sum0", gotQ[0], 10000);
      chk("b2b_sum1", gotQ[1], -1);
      chk("b2b_gap", longint'(gotCyc[1] - gotCyc[0]), 1);
    end

    // Output stall with two last beats pending
    gotQ.delete();
    gotCyc.delete();
    out_ready = 1'b0;
    beat(5, 5, 1'b1);
    beat(6, -6, 1'b1);
    chk("stall_in_ready", longint'(in_ready), 0);
    chk("stall_out_valid", longint'(out_valid), 1);
    chk("stall_out_sum", longint'(out_sum), 25);
    in_a = 13'sd7; in_b = 13'sd1; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_hold_ready", longint'(in_ready), 0);
    chk("stall_hold_sum", longint'(out_sum), 25);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle();
    waitResults("stall_wait", 3);
    if (gotQ.size() >= 3) begin
      chk("stall_res0", gotQ[0], 25);
      chk("stall_res1", gotQ[1], -36);
      chk("stall_res2", gotQ[2], 7);
    end

    // Reset mid-dot-product with a held output
    gotQ.delete();
    gotCyc.delete();
    out_ready = 1'b0;
    beat(1, 1, 1'b1);
    beat(9, 9, 1'b0);
    beat(3, 3, 1'b0);
    idle();
    @(negedge clk);
    chk("prerst_held", longint'(out_valid), 1);
    doReset();
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_out_sum", longint'(out_sum), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    out_ready = 1'b1;
    beat(2, 2, 1'b1);
    idle();
    waitResults("midrst_wait", 1);
    repeat (3) @(negedge clk);
    chk("midrst_count", longint'(gotQ.size()), 1);
    if (gotQ.size() >= 1) chk("midrst_sum", gotQ[0], 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
